jam_cost_scheduler: RTL and testbench
=====================================

# jam_cost_scheduler

Shared-resource scheduler for the job-assignment (JAM) cost engine. It lets up to NREQ permutation generators share the single external cost-table port (W/J in, Cost back). For each granted requester it walks all 8 workers, totals the 8 looked-up costs, and returns the 10-bit total to that requester. It sits between the permutation engines and the cost ROM, replacing per-engine direct ROM access.

## Interface
- NREQ, 4, number of requesting permutation engines (2..8)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester evaluation request; level, held until ack
- perm  in  NREQ*24  flattened permutations; requester i uses bits [24i+23:24i]; job for worker k at [24i+3k+2:24i+3k]
- ack  out  NREQ  one-cycle pulse: request i accepted and its perm captured
- W  out  3  worker index to cost ROM (registered)
- J  out  3  job index to cost ROM (registered)
- Cost  in  7  cost ROM data, combinational from W/J, valid in the same cycle
- done  out  NREQ  one-cycle pulse: total for requester i is on sum
- sum  out  10  total cost of the last evaluation; held until the next done
- busy  out  1  high in FETCH and DONE

## Operation
- States:
  - IDLE: no evaluation in progress; arbitrates among pending requests.
  - FETCH: 8 cycles; step counter k runs 0..7.
  - DONE: 1 cycle; result returned.
- IDLE with any req high:
  - Round-robin pick g, starting the search at the priority pointer.
  - Latch perm of g; pulse ack[g].
  - Clear the accumulator; set W=0, J=perm_g[2:0]; go to FETCH.
- IDLE with no req high: stay in IDLE; W=J=0.
- FETCH, step k: W=k, J=latched job k.
  - At the edge: acc += Cost (zero-extended to 10 bits).
  - k<7: advance to k+1 and update W/J.
  - k=7: sum <= acc+Cost, done[g] pulses in the next cycle, go to DONE.
- DONE:
  - done[g]=1 for exactly this cycle.
  - Priority pointer <= (g+1) mod NREQ.
  - W=J=0; go to IDLE.
- Arithmetic: the maximum total is 8×127=1016, which fits in 10 bits. No saturation or overflow logic.
- Cost is ignored outside FETCH.
- A req that stays high after its ack is treated as a new request at the next IDLE.
- req edges while busy are ignored until the next IDLE arbitration; no queueing in the block.
- perm is sampled only at the grant edge. The requester may change perm from the ack cycle onward.
- The permutation is not checked for uniqueness; duplicate jobs are summed as given.

## Timing
- Reset values: W=0, J=0, ack=0, done=0, sum=0, busy=0, state=IDLE, pointer=0, acc=0.
- A request seen high at IDLE edge e0 gives:
  - ack high in cycle e0+1, with FETCH k=0 in that same cycle.
  - FETCH k=7 in cycle e0+8.
  - done in cycle e0+9 (DONE).
  - IDLE in e0+10.
- Throughput: one evaluation per 10 cycles with continuous requests.
- ack and done are never high in the same cycle.
- At most one bit of ack, and one bit of done, is high at a time.
- RST mid-FETCH or mid-DONE:
  - Evaluation aborts; no done.
  - Outputs return to reset values on the next edge.
  - Any request pending at reset must be re-arbitrated.
- Simultaneous requests: the lowest index at or after the pointer wins. All others wait; none is starved (worst wait (NREQ−1)×10 cycles).

## Structure
- Shared package jam_pkg holds:
  - constants NW=8, IDX_W=3, COST_W=7, SUM_W=10, PERM_W=24;
  - state enum IDLE/FETCH/DONE.
- One sub-module, jam_rr_arbiter: NREQ-wide round-robin grant.
  - Inputs: req, pointer. Outputs: one-hot grant, grant index, any.
  - Combinational; the pointer register stays in the parent.
- Parent contains the FSM, step counter, perm latch, accumulator and output registers.

## Test plan
- TB ROM cost(w,j)=8w+j; requester 0 with identity perm {7,6,5,4,3,2,1,0} packed.
  - Expect ack[0] at +1 and done[0] at +9.
  - Expect sum=252, and W/J sequence (0,0)…(7,7).
- Same ROM, reversed perm (job 7−w) -> sum=8·28+28=252. Same ROM, perm job=(w+1) mod 8 -> sum=224+28=252. Then ROM cost(w,j)=w·j with identity -> sum=140.
- ROM all 127, any perm -> sum=1016 with no wrap.
- All 4 req high from reset, held until ack:
  - ack order 0,1,2,3, 10 cycles apart.
  - Then req re-raised on 0 and 3 with pointer at 0 -> 0 granted before 3.
- RST asserted at FETCH k=4:
  - No done pulse.
  - Next cycle: W=J=0, busy=0, sum=0.
  - Re-request completes normally with the correct sum.
- req[1] dropped the cycle after ack while perm[1] changes -> the result uses the perm captured at grant, and no second ack for requester 1.

Source files
------------

// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared constants and state encoding for the JAM cost scheduler
package jam_pkg;

   localparam int NW     = 8;
   localparam int IDX_W  = 3;
   localparam int COST_W = 7;
   localparam int SUM_W  = 10;
   localparam int PERM_W = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/jam_rr_arbiter.sv
// rtl/jam_rr_arbiter.sv - combinational round-robin grant, search starts at i_ptr
module jam_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_gidx,
   output logic            o_any
);

   logic [NREQ-1:0] w_rot;
   logic [PW-1:0]   w_off;
   logic [PW:0]     w_sum;
   logic            w_found;

   // w_rot[j] is the request j places after the pointer, so the lowest set bit wins
   always_comb begin
      w_rot   = '0;
      w_off   = '0;
      w_found = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         w_rot[j] = i_req[(int'(i_ptr) + j) % NREQ];
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!w_found && w_rot[j]) begin
            w_off   = PW'(j);
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= (PW+1)'(NREQ)) begin
         w_sum = w_sum - (PW+1)'(NREQ);
      end
   end

   assign o_any   = |i_req;
   assign o_gidx  = w_sum[PW-1:0];
   assign o_grant = o_any ? ({{(NREQ-1){1'b0}}, 1'b1} << o_gidx) : '0;

endmodule

// File: rtl/jam_cost_scheduler.sv
// rtl/jam_cost_scheduler.sv - arbitrates permutation engines onto the shared cost ROM
// and returns the 8-worker cost total to the granted requester.
module jam_cost_scheduler
   import jam_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*PERM_W-1:0] perm,
   output logic [NREQ-1:0]        ack,
   output logic [IDX_W-1:0]       W,
   output logic [IDX_W-1:0]       J,
   input  logic [COST_W-1:0]      Cost,
   output logic [NREQ-1:0]        done,
   output logic [SUM_W-1:0]       sum,
   output logic                   busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t             r_state;
   state_t             w_next_state;
   logic [IDX_W-1:0]   r_k;
   logic [PERM_W-1:0]  r_perm;
   logic [PW-1:0]      r_gidx;
   logic [PW-1:0]      r_ptr;
   logic [SUM_W-1:0]   r_acc;
   logic [SUM_W-1:0]   r_sum;
   logic [IDX_W-1:0]   r_w;
   logic [IDX_W-1:0]   r_j;
   logic [NREQ-1:0]    r_ack;
   logic [NREQ-1:0]    r_done;

   logic [NREQ-1:0]    w_grant;
   logic [PW-1:0]      w_gidx;
   logic               w_any;
   logic [PERM_W-1:0]  w_perm_g;
   logic [IDX_W-1:0]   w_k_next;
   logic [SUM_W-1:0]   w_cost_ext;
   logic               w_last_step;

   jam_rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_gidx  (w_gidx),
      .o_any   (w_any)
   );

   assign w_perm_g    = perm[int'(w_gidx)*PERM_W +: PERM_W];
   assign w_k_next    = r_k + IDX_W'(1);
   assign w_cost_ext  = {{(SUM_W-COST_W){1'b0}}, Cost};
   assign w_last_step = (r_k == IDX_W'(NW - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next_state = FETCH;
         FETCH:   if (w_last_step) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_k    <= '0;
         r_perm <= '0;
         r_gidx <= '0;
         r_ptr  <= '0;
         r_acc  <= '0;
         r_sum  <= '0;
         r_w    <= '0;
         r_j    <= '0;
         r_ack  <= '0;
         r_done <= '0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         case (r_state)
            IDLE: begin
               r_w <= '0;
               r_j <= '0;
               if (w_any) begin
                  r_perm <= w_perm_g;
                  r_gidx <= w_gidx;
                  r_ack  <= w_grant;
                  r_acc  <= '0;
                  r_k    <= '0;
                  r_j    <= w_perm_g[IDX_W-1:0];
               end
            end
            FETCH: begin
               r_acc <= r_acc + w_cost_ext;
               if (w_last_step) begin
                  r_sum  <= r_acc + w_cost_ext;
                  r_done <= {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
                  r_w    <= '0;
                  r_j    <= '0;
               end else begin
                  r_k <= w_k_next;
                  r_w <= w_k_next;
                  r_j <= r_perm[int'(w_k_next)*IDX_W +: IDX_W];
               end
            end
            DONE: begin
               r_w   <= '0;
               r_j   <= '0;
               r_ptr <= (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);
            end
            default: begin
               r_w <= '0;
               r_j <= '0;
            end
         endcase
      end
   end

   assign ack  = r_ack;
   assign done = r_done;
   assign W    = r_w;
   assign J    = r_j;
   assign sum  = r_sum;
   assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_jam_cost_scheduler.sv
// tb/tb_jam_cost_scheduler.sv - randomized and directed self-checking bench for jam_cost_scheduler
module tb_jam_cost_scheduler;

   logic        CLK;
   logic        RST;
   logic [3:0]  req;
   logic [95:0] perm;
   logic [3:0]  ack;
   logic [2:0]  W;
   logic [2:0]  J;
   logic [6:0]  Cost;
   logic [3:0]  done;
   logic [9:0]  sum;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   int          tb_ptr = 0;
   int          rom_mode = 0;
   logic        mon_en = 1'b0;
   logic [6:0]  rom_tab [64];

   jam_cost_scheduler #(.NREQ(4)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .req  (req),
      .perm (perm),
      .ack  (ack),
      .W    (W),
      .J    (J),
      .Cost (Cost),
      .done (done),
      .sum  (sum),
      .busy (busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // cost ROM: 0 -> 8w+j, 1 -> w*j, 2 -> all 127, 3 -> random table
   always_comb begin
      case (rom_mode)
         0:       Cost = {1'b0, W, J};
         1:       Cost = 7'({4'b0, W} * {4'b0, J});
         2:       Cost = 7'd127;
         default: Cost = rom_tab[{W, J}];
      endcase
   end

   function automatic int model_rom(input int w, input int j);
      case (rom_mode)
         0:       return 8 * w + j;
         1:       return w * j;
         2:       return 127;
         default: return int'(rom_tab[w * 8 + j]);
      endcase
   endfunction

   function automatic int model_sum(input logic [23:0] p);
      int s = 0;
      for (int w = 0; w < 8; w++) s += model_rom(w, int'(p[3*w +: 3]));
      return s;
   endfunction

   function automatic logic [23:0] pack_perm(input int kind);
      logic [23:0] p = '0;
      for (int w = 0; w < 8; w++) begin
         case (kind)
            0:       p[3*w +: 3] = 3'(w);
            1:       p[3*w +: 3] = 3'(7 - w);
            default: p[3*w +: 3] = 3'((w + 1) % 8);
         endcase
      end
      return p;
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         chk("pulse_rules", {47'd0, (|ack & |done) | !$onehot0(ack) | !$onehot0(done)}, 48'd0);
      end
   end

   task automatic serve(input logic [3:0] mask, input string tag);
      int          exp_order[$];
      int          exp_sum[4];
      logic [23:0] saved[4];
      int          ack_i[$];
      int          ack_c[$];
      int          done_i[$];
      int          done_c[$];
      int          sums[$];
      logic [5:0]  tr[$];
      int          n;
      int          budget;
      for (int o = 0; o < 4; o++) begin
         if (mask[(tb_ptr + o) % 4]) exp_order.push_back((tb_ptr + o) % 4);
      end
      for (int i = 0; i < 4; i++) begin
         saved[i]   = perm[24*i +: 24];
         exp_sum[i] = model_sum(saved[i]);
      end
      budget = 10 * exp_order.size() + 20;
      @(negedge CLK);
      req = req | mask;
      n = 0;
      while (done_i.size() < exp_order.size() && n < budget) begin
         @(negedge CLK);
         n++;
         for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
               ack_i.push_back(i);
               ack_c.push_back(n);
               req[i] = 1'b0;
               perm[24*i +: 24] = 24'($urandom);
            end
            if (done[i]) begin
               done_i.push_back(i);
               done_c.push_back(n);
               sums.push_back(int'(sum));
            end
         end
         if (busy && done == 4'b0) tr.push_back({W, J});
      end
      repeat (3) begin
         @(negedge CLK);
         for (int i = 0; i < 4; i++) if (ack[i]) ack_i.push_back(i);
      end
      chk({tag, "_ndone"}, 48'(done_i.size()), 48'(exp_order.size()));
      chk({tag, "_nack"}, 48'(ack_i.size()), 48'(exp_order.size()));
      foreach (exp_order[k]) begin
         if (k < ack_c.size()) begin
            chk({tag, "_ack_idx"}, 48'(ack_i[k]), 48'(exp_order[k]));
            chk({tag, "_ack_cyc"}, 48'(ack_c[k]), 48'(1 + 10 * k));
         end
         if (k < done_i.size()) begin
            chk({tag, "_done_idx"}, 48'(done_i[k]), 48'(exp_order[k]));
            chk({tag, "_done_cyc"}, 48'(done_c[k]), 48'(9 + 10 * k));
            chk({tag, "_sum"}, 48'(sums[k]), 48'(exp_sum[exp_order[k]]));
         end
      end
      if (exp_order.size() == 1) begin
         chk({tag, "_wj_len"}, 48'(tr.size()), 48'd8);
         foreach (tr[k]) begin
            if (k < 8) chk({tag, "_wj"}, 48'(tr[k]), 48'({3'(k), saved[exp_order[0]][3*k +: 3]}));
         end
      end
      if (exp_order.size() > 0) tb_ptr = (exp_order[exp_order.size() - 1] + 1) % 4;
   endtask

   initial begin
      int n;
      int dn;
      logic [3:0] mask;
      RST  = 1'b1;
      req  = '0;
      perm = '0;
      for (int i = 0; i < 64; i++) rom_tab[i] = 7'($urandom_range(0, 127));
      repeat (3) @(negedge CLK);
      chk("rst_W", 48'(W), 48'd0);
      chk("rst_J", 48'(J), 48'd0);
      chk("rst_ack", 48'(ack), 48'd0);
      chk("rst_done", 48'(done), 48'd0);
      chk("rst_sum", 48'(sum), 48'd0);
      chk("rst_busy", 48'(busy), 48'd0);
      RST = 1'b0;
      mon_en = 1'b1;

      rom_mode = 0;
      perm = {$urandom(), $urandom(), $urandom()};
      serve(4'hF, "rr4");
      serve(4'b1001, "rr03");

      perm[23:0] = pack_perm(0);
      serve(4'b0001, "ident");
      chk("ident_sum_abs", 48'(sum), 48'd252);
      perm[23:0] = pack_perm(1);
      serve(4'b0001, "rev");
      chk("rev_sum_abs", 48'(sum), 48'd252);
      perm[23:0] = pack_perm(2);
      serve(4'b0001, "rot");
      chk("rot_sum_abs", 48'(sum), 48'd252);
      rom_mode = 1;
      perm[23:0] = pack_perm(0);
      serve(4'b0001, "wxj");
      chk("wxj_sum_abs", 48'(sum), 48'd140);
      rom_mode = 2;
      perm[23:0] = 24'($urandom);
      serve(4'b0001, "max");
      chk("max_sum_abs", 48'(sum), 48'd1016);

      rom_mode = 3;
      perm[47:24] = 24'($urandom);
      serve(4'b0010, "drop1");

      rom_mode = 0;
      perm[23:0] = 24'($urandom);
      @(negedge CLK);
      req[0] = 1'b1;
      n = 0;
      while (n < 5) begin
         @(negedge CLK);
         n++;
         if (ack[0]) req[0] = 1'b0;
      end
      chk("rst_mid_k4", 48'(W), 48'd4);
      req[0] = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      tb_ptr = 0;
      chk("abort_W", 48'(W), 48'd0);
      chk("abort_J", 48'(J), 48'd0);
      chk("abort_busy", 48'(busy), 48'd0);
      chk("abort_sum", 48'(sum), 48'd0);
      chk("abort_done", 48'(done), 48'd0);
      dn = 0;
      repeat (12) begin
         @(negedge CLK);
         if (|done) dn++;
      end
      chk("abort_no_done", 48'(dn), 48'd0);
      serve(4'b0001, "after_rst");

      rom_mode = 3;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 64; i++) rom_tab[i] = 7'($urandom_range(0, 127));
         perm = {$urandom(), $urandom(), $urandom()};
         mask = 4'($urandom_range(1, 15));
         serve(mask, "rnd");
      end

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
